// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: ALU operation codes,
// LEGv8 ALUOp values, R-type opcode constants and the FSM state encoding.
package alu_issue_pkg;

  // ALU operation codes presented on alu_operation
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  // LEGv8 ALUOp values from the main control unit
  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // R-type opcodes, instr[31:21]
  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;
  localparam logic [10:0] OPC_DIV = 11'b10011010110;

  // Issue FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } alu_issue_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/opcode to ALU operation decoder. Unknown encodings
// raise illegal and leave the operation at NOP.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0]  aluop,
  input  logic [10:0] opcode,
  output logic [2:0]  alu_operation,
  output logic        illegal
);

  // Decode ALUOp first; R-type instructions are refined by opcode
  always_comb begin
    alu_operation = ALU_NOP;
    illegal       = 1'b0;
    case (aluop)
      ALUOP_LDST: alu_operation = ALU_ADD;
      ALUOP_CBZ:  alu_operation = ALU_PASS;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: alu_operation = ALU_ADD;
          OPC_SUB: alu_operation = ALU_SUB;
          OPC_MUL: alu_operation = ALU_MUL;
          OPC_DIV: alu_operation = ALU_DIV;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external multi-cycle ALU. Accepts one request in
// IDLE, drives the ALU for a fixed number of EXEC cycles, then holds the
// captured response in RESP until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a producer holds valid and
// its payload stable until that transfer edge.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int SETTLE_CYC = 1,
  parameter int DIV_CYC    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [10:0]       req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_error,
  output alu_issue_state_e  dbg_state
);

  alu_issue_state_e  state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_error_q, rsp_error_d;

  logic [2:0] dec_op;
  logic       dec_illegal;
  logic       div_by_zero;

  alu_op_decode u_decode (
    .aluop         (req_aluop),
    .opcode        (req_opcode),
    .alu_operation (dec_op),
    .illegal       (dec_illegal)
  );

  assign div_by_zero = (dec_op == ALU_DIV) && (req_b == '0);

  // Next-state and datapath register updates for the issue FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_error_d  = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d = req_a;
          alu_b_d = req_b;
          if (dec_illegal || div_by_zero) begin
            // Nothing for the ALU to do: answer with an error at once
            op_d         = ALU_NOP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
            rsp_error_d  = 1'b1;
            state_d      = ST_RESP;
          end else begin
            op_d    = dec_op;
            cnt_d   = (dec_op == ALU_DIV) ? 4'(DIV_CYC) : 4'(SETTLE_CYC);
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q <= 4'd1) begin
          op_d         = ALU_NOP;
          cnt_d        = 4'd0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_error_d  = 1'b0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        op_d        = ALU_NOP;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      op_q         <= ALU_NOP;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && reset_n;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_operation = op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_error     = rsp_error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int DW = 64;
  localparam int W  = DW + 2;

  logic          clk, reset_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_aluop;
  logic [10:0]   req_opcode;
  logic [DW-1:0] req_a, req_b;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_operation;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_zero, rsp_error;
  logic [DW-1:0] rsp_result;
  alu_issue_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.DATA_W(DW), .SETTLE_CYC(1), .DIV_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_error(rsp_error), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      3'b010: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b100: alu_result = alu_a * alu_b;
      3'b011: alu_result = (alu_b != '0) ? alu_a / alu_b : '0;
      3'b101: alu_result = alu_a;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the expected queue
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result 0x%0h with empty queue", rsp_result);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_payload", {62'd0, rsp_result, rsp_zero, rsp_error}, {62'd0, e});
      end
    end
  end

  // Driver: issue one request, check EXEC opcode and response latency
  task automatic do_req(input string name, input logic [1:0] op, input logic [10:0] opc,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] er, input logic ez, input logic ee,
                        input int lat, input logic [2:0] ecode, input bit push);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: req_ready 0 expected 1", name);
      return;
    end
    req_valid = 1'b1; req_aluop = op; req_opcode = opc; req_a = a; req_b = b;
    if (push) exp_q.push_back({er, ez, ee});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, "_alu_op"}, 128'(alu_operation), 128'(ecode));
    if (lat > 0) begin
      chk({name, "_alu_a"}, 128'(alu_a), 128'(a));
      chk({name, "_alu_b"}, 128'(alu_b), 128'(b));
    end
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, 128'(n), 128'(lat));
    if (rsp_ready) begin
      n = 0;
      while (rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk({name, "_rsp_drop"}, 128'(rsp_valid), 128'(0));
    end
  endtask

  initial begin
    logic [DW-1:0] hold_res;
    logic          hold_z, hold_e;
    bit            seen_div;
    reset_n = 1'b0; req_valid = 1'b0; req_aluop = '0; req_opcode = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Reset state
    #12;
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_outputs", {rsp_result, 3'd0, rsp_zero, rsp_error, alu_operation},
        128'(0));
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 128'(req_ready), 128'(1));

    // Main function
    do_req("add", 2'b10, 11'b10001011000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1, 3'b010, 1);
    chk("alu_a_hold", 128'(alu_a), 128'(5));
    do_req("sub_eq", 2'b10, 11'b11001011000, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 1, 3'b001, 1);
    do_req("mul", 2'b10, 11'b10011011000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1, 3'b100, 1);
    do_req("div", 2'b10, 11'b10011010110, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 4, 3'b011, 1);
    do_req("div0", 2'b10, 11'b10011010110, 64'd100, 64'd0, 64'd0, 1'b1, 1'b1, 0, 3'b000, 1);
    do_req("ldst", 2'b00, 11'd0, 64'd40, 64'd2, 64'd42, 1'b0, 1'b0, 1, 3'b010, 1);
    do_req("cbz", 2'b01, 11'd0, 64'd0, 64'd9, 64'd0, 1'b1, 1'b0, 1, 3'b101, 1);
    do_req("ill_aluop", 2'b11, 11'b10001011000, 64'd5, 64'd6, 64'd0, 1'b1, 1'b1, 0, 3'b000, 1);
    do_req("ill_opc", 2'b10, 11'b00000000001, 64'd5, 64'd6, 64'd0, 1'b1, 1'b1, 0, 3'b000, 1);

    // Backpressure: response held while rsp_ready low, new requests ignored
    rsp_ready = 1'b0;
    do_req("bp", 2'b10, 11'b10001011000, 64'd20, 64'd22, 64'd42, 1'b0, 1'b0, 1, 3'b010, 1);
    hold_res = rsp_result; hold_z = rsp_zero; hold_e = rsp_error;
    req_valid = 1'b1; req_aluop = 2'b10; req_opcode = 11'b11001011000;
    req_a = 64'd99; req_b = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", {61'd0, rsp_valid, rsp_result, rsp_zero, rsp_error, req_ready},
          {61'd0, 1'b1, 64'd42, 1'b0, 1'b0, 1'b0});
    end
    chk("bp_held_prev", {62'd0, hold_res, hold_z, hold_e}, {62'd0, rsp_result, rsp_zero, rsp_error});
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {126'd0, rsp_valid, req_ready}, 128'b01);

    // Reset in the middle of a divide: no response may follow
    do_req("pre_rst", 2'b10, 11'b10001011000, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1, 3'b010, 1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_aluop = 2'b10; req_opcode = 11'b10011010110;
    req_a = 64'd100; req_b = 64'd7;
    @(posedge clk); #1;             // T0
    req_valid = 1'b0;
    chk("rst_div_started", 128'(alu_operation), 128'(3'b011));
    @(posedge clk); #1;             // T0+1
    @(posedge clk); #1;             // T0+2
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {alu_a, alu_b}, 128'(0));
    chk("rst_mid_ctrl", {119'd0, alu_operation, rsp_valid, rsp_zero, rsp_error, req_ready,
        rsp_result == '0}, 128'(1));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", 128'(req_ready), 128'(1));
    seen_div = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || alu_operation == 3'b011) seen_div = 1'b1;
    end
    chk("rst_no_rsp", 128'(seen_div), 128'(0));

    // Everything issued has been answered exactly once
    repeat (3) @(posedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width.
REQ-002 SHALL have parameter SETTLE_CYC, default 1, EXEC cycles for add/sub/pass/mul (legal range 1..15).
REQ-003 SHALL have parameter DIV_CYC, default 4, EXEC cycles for divide (legal range 1..15).
REQ-004 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid in 1; req_ready out 1; req_aluop in 2 (LEGv8 ALUOp); req_opcode in 11 (instr[31:21]); req_a in DATA_W; req_b in DATA_W.
REQ-006 SHALL have ports: alu_a out DATA_W; alu_b out DATA_W; alu_operation out 3; alu_result in DATA_W; alu_zero in 1.
REQ-007 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_result out DATA_W; rsp_zero out 1; rsp_error out 1.

Function
REQ-008 SHALL decode ALUOp 00 -> 3'b010 (add), 01 -> 3'b101 (pass a, CBZ), 11 -> illegal.
REQ-009 SHALL decode ALUOp 10 by opcode: 10001011000 -> 010 (ADD), 11001011000 -> 001 (SUB), 10011011000 -> 100 (MUL), 10011010110 -> 011 (DIV); any other opcode -> illegal.
REQ-010 SHALL implement FSM IDLE, EXEC, RESP; req_ready = 1 only in IDLE with reset_n high.
REQ-011 SHALL on IDLE with req_valid&req_ready at edge T0 register req_a/req_b to alu_a/alu_b and decoded code to alu_operation, load cycle counter, enter EXEC.
REQ-012 SHALL stay in EXEC for SETTLE_CYC cycles (DIV_CYC for 011), then at the final EXEC edge capture alu_result/alu_zero into rsp_result/rsp_zero, set rsp_valid, enter RESP; with SETTLE_CYC=1, rsp_valid is high after edge T0+1.
REQ-013 SHALL for illegal decode or DIV with req_b == 0 skip EXEC: at T0 enter RESP with rsp_result 0, rsp_zero 1, rsp_error 1, alu_operation 000.
REQ-014 SHALL hold rsp_valid, rsp_result, rsp_zero, rsp_error stable in RESP until rsp_ready sampled high; at that edge clear rsp_valid and return to IDLE.
REQ-015 SHALL drive alu_operation 000 in IDLE and RESP; alu_a/alu_b hold their last values outside EXEC.
REQ-016 SHALL ignore req_* outside IDLE; no request is lost or duplicated; throughput at most one request per SETTLE_CYC+2 cycles.
REQ-017 SHALL treat add/sub/mul results as modulo 2^DATA_W, passing alu_result unchanged.

Reset
REQ-018 SHALL while reset_n low force state IDLE, counter 0, alu_a 0, alu_b 0, alu_operation 000, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_error 0, req_ready 0, asynchronously.
REQ-019 SHALL abandon any in-flight operation on reset with no response produced; req_ready = 1 on the first cycle after release.

Structure
REQ-020 SHALL put ALU op codes (010/001/100/011/101/000), ALUOp values, the four opcode constants and the state encoding in shared package alu_issue_pkg.
REQ-021 SHALL isolate decode in one combinational sub-module alu_op_decode (aluop, opcode -> alu_operation, illegal); FSM, counter and registers stay in alu_issue_ctrl.

Verification
REQ-022 ADD: aluop 10, opcode 10001011000, a=5, b=7 -> alu_operation 010 in EXEC, rsp_valid after T0+1, rsp_result 12, zero 0, error 0.
REQ-023 SUB equal: a=b=0x1234 opcode 11001011000 -> rsp_result 0, rsp_zero 1; MUL a=3, b=0xFFFF_FFFF_FFFF_FFFF -> rsp_result 0xFFFF_FFFF_FFFF_FFFD.
REQ-024 DIV: a=100, b=7 -> rsp_valid after T0+4, rsp_result 14; a=100, b=0 -> rsp_valid after T0, result 0, zero 1, error 1, alu_operation never 011.
REQ-025 Backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready 0, new req_valid ignored; rsp_ready high -> IDLE next edge, req_ready 1.
REQ-026 Reset mid-DIV (reset_n low at T0+2) -> all outputs 0 immediately, no rsp_valid after release; illegal aluop 11 -> rsp_error 1, rsp_result 0.
